pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Parametrised arbiter that multiplexes NUM_PORTS cache-line clients (e.g. split I-cache and D-cache miss handlers) onto the single physical-memory port exported by the processor top level. Each client uses the same hold-until-resp read/write handshake as the pmem port. Requests are latched, then serviced one full line at a time; round-robin or fixed-priority selection is chosen at compile time. The block sits between the cache layer and pmem, replacing the direct single-cache-to-pmem connection.

## Interface
- NUM_PORTS, 2, number of clients (≥2)
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 256, cache line width in bits
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- client_read  in  NUM_PORTS  per-client line read request, held until its resp
- client_write  in  NUM_PORTS  per-client line write request, held until its resp
- client_address  in  NUM_PORTS*ADDR_WIDTH  packed; client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- client_wdata  in  NUM_PORTS*LINE_WIDTH  packed write lines, same packing
- client_resp  out  NUM_PORTS  one-cycle completion pulse, at most one bit set
- client_rdata  out  LINE_WIDTH  shared read line, valid while any client_resp bit is high
- pmem_read  out  1  line read to memory
- pmem_write  out  1  line write to memory
- pmem_address  out  ADDR_WIDTH  latched address of granted client
- pmem_wdata  out  LINE_WIDTH  latched write line of granted client
- pmem_resp  in  1  memory completion
- pmem_rdata  in  LINE_WIDTH  memory read line

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: pending = client_read | client_write. If nonzero, select winner g per policy; at the edge latch g, op (write if client_write[g], else read), address and wdata of g; go BUSY. Otherwise stay.
- BUSY: pmem_read or pmem_write high per latched op, address/wdata from latches, stable whole state. On pmem_resp=1: capture pmem_rdata into rdata register, go RESP.
- RESP: client_resp[g]=1 for exactly this cycle, client_rdata = captured line; pmem_read/pmem_write low. Go IDLE unconditionally.
- Client drops its request on the edge ending RESP, so IDLE never re-grants a completed request.
- Client asserting read and write together: illegal; arbiter services it as a write.
- Requests of non-granted clients are ignored (not latched) until next IDLE; they must stay asserted.
- Client changing address/wdata while granted: no effect (latched copy used).

## Timing
- Reset (async on rst_n low): state IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, client_resp=0, client_rdata=0, RR pointer=0. Reset mid-BUSY abandons the pmem transaction immediately; no client_resp issued.
- Request high in IDLE cycle 0 -> pmem cmd high from cycle 1.
- pmem_resp in cycle k -> pmem cmd low and client_resp high in cycle k+1 -> IDLE in k+2.
- Minimum turnaround: 3 cycles per transaction with 1-cycle pmem; back-to-back grants separated by one IDLE cycle.
- pmem_resp outside BUSY ignored.

## Configuration
- PMEM_ARB_RR_EN defined: round-robin. Search starts at pointer p, ascending mod NUM_PORTS; on grant to g, p <= (g+1) mod NUM_PORTS.
- Undefined: fixed priority, lowest index wins; pointer logic absent. Starvation of high indices possible and accepted.

## Test plan
- Single read, NUM_PORTS=2: client 0 read addr 0x0000_1000, pmem returns 256'hA5..A5 after 4 cycles -> pmem_read cycles 1-5, client_resp=2'b01 one cycle, client_rdata=A5..A5.
- Single write: client 1 write addr 0x0000_2040, wdata 256'h1234 -> pmem_write=1, pmem_address=0x2040, pmem_wdata=0x1234; client_resp=2'b10 one pulse.
- Simultaneous: both request in same cycle, RR_EN -> client 0 served, then client 1; without RR_EN and client 0 re-requesting immediately -> client 0 served twice before client 1.
- Client changes address to 0xDEAD_BEE0 during BUSY -> pmem_address remains original latched value.
- rst_n low mid-BUSY -> pmem_read drops same cycle asynchronously, no client_resp; after release, new request served normally with RR pointer 0.
- NUM_PORTS=4, RR_EN, all four continuously requesting -> grant order 0,1,2,3,0 with exactly one resp pulse each.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Multi-client cache-line arbiter onto a single hold-until-resp pmem port.
// Define PMEM_ARB_RR_EN for round-robin selection; default is fixed priority (lowest index wins).
module pmem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             client_read,
    input  logic [NUM_PORTS-1:0]             client_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  client_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  client_wdata,
    output logic [NUM_PORTS-1:0]             client_resp,
    output logic [LINE_WIDTH-1:0]            client_rdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [LINE_WIDTH-1:0]            pmem_wdata,
    input  logic                             pmem_resp,
    input  logic [LINE_WIDTH-1:0]            pmem_rdata
);

    localparam int IDXW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t                                 r_state;
    logic [IDXW-1:0]                        r_grant;
    logic [IDXW-1:0]                        w_win;
    logic [NUM_PORTS-1:0]                   w_pending;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   w_addr;
    logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]   w_wdata;

    assign w_pending = client_read | client_write;
    assign w_addr    = client_address;
    assign w_wdata   = client_wdata;

`ifdef PMEM_ARB_RR_EN
    logic [IDXW-1:0]                  r_rr_ptr;
    logic [NUM_PORTS-1:0][IDXW-1:0]   w_rot;

    // w_rot[k] is the k-th candidate in search order starting at the pointer.
    for (genvar gk = 0; gk < NUM_PORTS; gk++) begin : g_rot
        assign w_rot[gk] = IDXW'((int'(r_rr_ptr) + gk) % NUM_PORTS);
    end

    always_comb begin
        w_win = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (w_pending[w_rot[k]]) w_win = w_rot[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_IDLE && |w_pending) begin
            if (w_win == IDXW'(NUM_PORTS - 1)) r_rr_ptr <= '0;
            else                               r_rr_ptr <= w_win + 1'b1;
        end
    end
`else
    always_comb begin
        w_win = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_pending[i]) w_win = IDXW'(i);
        end
    end
`endif

    // All outputs are registered; an async reset drops the pmem command at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            client_resp  <= '0;
            client_rdata <= '0;
        end else begin
            client_resp <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending) begin
                        r_grant      <= w_win;
                        pmem_write   <= client_write[w_win];
                        pmem_read    <= ~client_write[w_win];
                        pmem_address <= w_addr[w_win];
                        pmem_wdata   <= w_wdata[w_win];
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (pmem_resp) begin
                        pmem_read            <= 1'b0;
                        pmem_write           <= 1'b0;
                        client_rdata         <= pmem_rdata;
                        client_resp[r_grant] <= 1'b1;
                        r_state              <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a 2-port and a 4-port instance share clock and reset.
module tb_pmem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]   c2_rd, c2_wr, c2_resp;
    logic [63:0]  c2_addr;
    logic [511:0] c2_wd;
    logic [255:0] c2_rdata, p2_wd, p2_rdata;
    logic         p2_rd, p2_wr, p2_resp;
    logic [31:0]  p2_addr;

    logic [3:0]    c4_rd, c4_wr, c4_resp;
    logic [127:0]  c4_addr;
    logic [1023:0] c4_wd;
    logic [255:0]  c4_rdata, p4_wd, p4_rdata;
    logic          p4_rd, p4_wr, p4_resp;
    logic [31:0]   p4_addr;

    int n_chk = 0;
    int n_fail = 0;

    pmem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .LINE_WIDTH(256)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .client_read(c2_rd), .client_write(c2_wr), .client_address(c2_addr),
        .client_wdata(c2_wd), .client_resp(c2_resp), .client_rdata(c2_rdata),
        .pmem_read(p2_rd), .pmem_write(p2_wr), .pmem_address(p2_addr),
        .pmem_wdata(p2_wd), .pmem_resp(p2_resp), .pmem_rdata(p2_rdata)
    );

    pmem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .LINE_WIDTH(256)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .client_read(c4_rd), .client_write(c4_wr), .client_address(c4_addr),
        .client_wdata(c4_wd), .client_resp(c4_resp), .client_rdata(c4_rdata),
        .pmem_read(p4_rd), .pmem_write(p4_wr), .pmem_address(p4_addr),
        .pmem_wdata(p4_wd), .pmem_resp(p4_resp), .pmem_rdata(p4_rdata)
    );

    // Waits (bounded) for the 2-port pmem command, holds it lat extra cycles,
    // pulses pmem_resp, then returns what the RESP cycle shows.
    task automatic serve2(input int lat, input logic [255:0] rd,
                          output logic [1:0] resp, output logic [255:0] rdat, output bit to);
        int n = 0;
        to = 1'b0;
        while (!(p2_rd || p2_wr) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin
            to = 1'b1; resp = '0; rdat = '0;
            return;
        end
        repeat (lat) begin @(posedge clk); #1; end
        p2_resp = 1'b1; p2_rdata = rd;
        @(posedge clk); #1;
        p2_resp = 1'b0;
        resp = c2_resp; rdat = c2_rdata;
    endtask

    task automatic test_reset;
        n_chk++; if (p2_rd !== 1'b0) begin n_fail++; $display("FAIL reset_p2_read: got %b want 0", p2_rd); end
        n_chk++; if (p2_wr !== 1'b0) begin n_fail++; $display("FAIL reset_p2_write: got %b want 0", p2_wr); end
        n_chk++; if (p2_addr !== 32'h0) begin n_fail++; $display("FAIL reset_p2_addr: got %h want 0", p2_addr); end
        n_chk++; if (p2_wd !== 256'h0) begin n_fail++; $display("FAIL reset_p2_wdata: got %h want 0", p2_wd); end
        n_chk++; if (c2_resp !== 2'b00) begin n_fail++; $display("FAIL reset_c2_resp: got %b want 00", c2_resp); end
        n_chk++; if (c2_rdata !== 256'h0) begin n_fail++; $display("FAIL reset_c2_rdata: got %h want 0", c2_rdata); end
        n_chk++; if (p4_rd !== 1'b0) begin n_fail++; $display("FAIL reset_p4_read: got %b want 0", p4_rd); end
        n_chk++; if (c4_resp !== 4'b0) begin n_fail++; $display("FAIL reset_c4_resp: got %b want 0000", c4_resp); end
    endtask

    task automatic test_single_read;
        @(posedge clk); #1;
        c2_addr[31:0] = 32'h0000_1000; c2_rd = 2'b01;
        n_chk++; if (p2_rd !== 1'b0) begin n_fail++; $display("FAIL rd_cycle0_cmd: got %b want 0", p2_rd); end
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            n_chk++; if (p2_rd !== 1'b1 || p2_wr !== 1'b0) begin
                n_fail++; $display("FAIL rd_busy_cmd cyc%0d: got rd=%b wr=%b want rd=1 wr=0", cyc, p2_rd, p2_wr); end
            n_chk++; if (p2_addr !== 32'h0000_1000) begin
                n_fail++; $display("FAIL rd_busy_addr cyc%0d: got %h want 00001000", cyc, p2_addr); end
            if (cyc == 5) begin p2_resp = 1'b1; p2_rdata = {32{8'hA5}}; end
        end
        @(posedge clk); #1;
        p2_resp = 1'b0;
        n_chk++; if (c2_resp !== 2'b01) begin n_fail++; $display("FAIL rd_resp: got %b want 01", c2_resp); end
        n_chk++; if (c2_rdata !== {32{8'hA5}}) begin n_fail++; $display("FAIL rd_rdata: got %h want a5..a5", c2_rdata); end
        n_chk++; if (p2_rd !== 1'b0) begin n_fail++; $display("FAIL rd_cmd_drop: got %b want 0", p2_rd); end
        c2_rd = 2'b00;
        @(posedge clk); #1;
        n_chk++; if (c2_resp !== 2'b00) begin n_fail++; $display("FAIL rd_resp_single: got %b want 00", c2_resp); end
        n_chk++; if (p2_rd !== 1'b0) begin n_fail++; $display("FAIL rd_no_regrant: got %b want 0", p2_rd); end
    endtask

    task automatic test_single_write;
        @(posedge clk); #1;
        c2_addr[63:32] = 32'h0000_2040; c2_wd[511:256] = 256'h1234; c2_wr = 2'b10;
        @(posedge clk); #1;
        n_chk++; if (p2_wr !== 1'b1 || p2_rd !== 1'b0) begin
            n_fail++; $display("FAIL wr_cmd: got rd=%b wr=%b want rd=0 wr=1", p2_rd, p2_wr); end
        n_chk++; if (p2_addr !== 32'h0000_2040) begin n_fail++; $display("FAIL wr_addr: got %h want 00002040", p2_addr); end
        n_chk++; if (p2_wd !== 256'h1234) begin n_fail++; $display("FAIL wr_wdata: got %h want 1234", p2_wd); end
        c2_addr[63:32] = 32'hDEAD_BEE0; c2_wd[511:256] = '1;
        @(posedge clk); #1;
        n_chk++; if (p2_addr !== 32'h0000_2040) begin n_fail++; $display("FAIL wr_addr_latched: got %h want 00002040", p2_addr); end
        n_chk++; if (p2_wd !== 256'h1234) begin n_fail++; $display("FAIL wr_wdata_latched: got %h want 1234", p2_wd); end
        n_chk++; if (p2_wr !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_hold: got %b want 1", p2_wr); end
        p2_resp = 1'b1;
        @(posedge clk); #1;
        p2_resp = 1'b0;
        n_chk++; if (c2_resp !== 2'b10) begin n_fail++; $display("FAIL wr_resp: got %b want 10", c2_resp); end
        n_chk++; if (p2_wr !== 1'b0) begin n_fail++; $display("FAIL wr_cmd_drop: got %b want 0", p2_wr); end
        c2_wr = 2'b00;
        @(posedge clk); #1;
        n_chk++; if (c2_resp !== 2'b00) begin n_fail++; $display("FAIL wr_resp_single: got %b want 00", c2_resp); end
    endtask

    task automatic test_rw_both;
        @(posedge clk); #1;
        c2_addr[31:0] = 32'h0000_0040; c2_wd[255:0] = 256'h55; c2_rd = 2'b01; c2_wr = 2'b01;
        @(posedge clk); #1;
        n_chk++; if (p2_wr !== 1'b1 || p2_rd !== 1'b0) begin
            n_fail++; $display("FAIL rw_as_write: got rd=%b wr=%b want rd=0 wr=1", p2_rd, p2_wr); end
        n_chk++; if (p2_wd !== 256'h55) begin n_fail++; $display("FAIL rw_wdata: got %h want 55", p2_wd); end
        p2_resp = 1'b1;
        @(posedge clk); #1;
        p2_resp = 1'b0;
        n_chk++; if (c2_resp !== 2'b01) begin n_fail++; $display("FAIL rw_resp: got %b want 01", c2_resp); end
        c2_rd = 2'b00; c2_wr = 2'b00;
        // Stray pmem_resp while idle must not produce a completion.
        @(posedge clk); #1;
        p2_resp = 1'b1;
        @(posedge clk); #1;
        p2_resp = 1'b0;
        n_chk++; if (c2_resp !== 2'b00 || p2_rd !== 1'b0 || p2_wr !== 1'b0) begin
            n_fail++; $display("FAIL idle_resp_ignored: got resp=%b rd=%b wr=%b want 00 0 0", c2_resp, p2_rd, p2_wr); end
    endtask

    task automatic test_reset_mid_busy;
        @(posedge clk); #1;
        c2_addr[31:0] = 32'h0000_3000; c2_rd = 2'b01;
        @(posedge clk); #1;
        n_chk++; if (p2_rd !== 1'b1) begin n_fail++; $display("FAIL rst_busy_cmd: got %b want 1", p2_rd); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (p2_rd !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: got %b want 0", p2_rd); end
        n_chk++; if (p2_addr !== 32'h0) begin n_fail++; $display("FAIL rst_async_addr: got %h want 0", p2_addr); end
        c2_rd = 2'b00;
        @(posedge clk); #1;
        p2_resp = 1'b1;
        @(posedge clk); #1;
        p2_resp = 1'b0;
        n_chk++; if (c2_resp !== 2'b00) begin n_fail++; $display("FAIL rst_no_resp: got %b want 00", c2_resp); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (c2_resp !== 2'b00 || p2_rd !== 1'b0) begin
            n_fail++; $display("FAIL rst_release_idle: got resp=%b rd=%b want 00 0", c2_resp, p2_rd); end
    endtask

    task automatic test_simultaneous;
        logic [1:0]   r;
        logic [255:0] d;
        bit           to;
        logic [1:0]   exp2, exp3;
`ifdef PMEM_ARB_RR_EN
        exp2 = 2'b10; exp3 = 2'b01;
`else
        exp2 = 2'b01; exp3 = 2'b10;
`endif
        @(posedge clk); #1;
        c2_addr = {32'h0000_B000, 32'h0000_A000}; c2_rd = 2'b11;
        serve2(1, 256'h11, r, d, to);
        n_chk++; if (to || r !== 2'b01) begin n_fail++; $display("FAIL sim_grant1: got %b timeout=%0d want 01", r, to); end
        n_chk++; if (d !== 256'h11) begin n_fail++; $display("FAIL sim_rdata1: got %h want 11", d); end
        serve2(0, 256'h22, r, d, to);
        n_chk++; if (to || r !== exp2) begin n_fail++; $display("FAIL sim_grant2: got %b timeout=%0d want %b", r, to, exp2); end
        n_chk++; if (d !== 256'h22) begin n_fail++; $display("FAIL sim_rdata2: got %h want 22", d); end
        c2_rd = c2_rd & ~r;
        serve2(2, 256'h33, r, d, to);
        n_chk++; if (to || r !== exp3) begin n_fail++; $display("FAIL sim_grant3: got %b timeout=%0d want %b", r, to, exp3); end
        c2_rd = 2'b00;
        @(posedge clk); #1;
        n_chk++; if (c2_resp !== 2'b00) begin n_fail++; $display("FAIL sim_resp_single: got %b want 00", c2_resp); end
    endtask

    task automatic test_four_port;
        int exp_g[5];
`ifdef PMEM_ARB_RR_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) c4_addr[i*32 +: 32] = 32'h100 * (i + 1);
        c4_rd = 4'hF;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            n_chk++; if (p4_rd !== 1'b1) begin n_fail++; $display("FAIL p4_busy_cmd t%0d: got %b want 1", t, p4_rd); end
            n_chk++; if (p4_addr !== 32'h100 * (exp_g[t] + 1)) begin
                n_fail++; $display("FAIL p4_addr t%0d: got %h want %h", t, p4_addr, 32'h100 * (exp_g[t] + 1)); end
            p4_resp = 1'b1; p4_rdata = 256'(t + 7);
            @(posedge clk); #1;
            p4_resp = 1'b0;
            n_chk++; if (c4_resp !== (4'b0001 << exp_g[t])) begin
                n_fail++; $display("FAIL p4_resp t%0d: got %b want %b", t, c4_resp, 4'b0001 << exp_g[t]); end
            n_chk++; if (c4_rdata !== 256'(t + 7)) begin n_fail++; $display("FAIL p4_rdata t%0d: got %h want %0h", t, c4_rdata, t + 7); end
            n_chk++; if (p4_rd !== 1'b0) begin n_fail++; $display("FAIL p4_cmd_drop t%0d: got %b want 0", t, p4_rd); end
            @(posedge clk); #1;
            n_chk++; if (c4_resp !== 4'b0 || p4_rd !== 1'b0) begin
                n_fail++; $display("FAIL p4_idle_gap t%0d: got resp=%b rd=%b want 0000 0", t, c4_resp, p4_rd); end
            if (t == 4) c4_rd = 4'h0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        c2_rd = '0; c2_wr = '0; c2_addr = '0; c2_wd = '0; p2_resp = 1'b0; p2_rdata = '0;
        c4_rd = '0; c4_wr = '0; c4_addr = '0; c4_wd = '0; p4_resp = 1'b0; p4_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        test_single_read;
        test_single_write;
        test_rw_both;
        test_reset_mid_busy;
        test_simultaneous;
        test_four_port;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
